fb_mem_arbiter: RTL and testbench
=================================

// Module: fb_mem_arbiter
// PURPOSE
//  Shares the single framebuffer memory controller port between two requesters:
//  - video row fetch (pixel_signal side): 32-byte row read into the line cache
//  - host byte writer: framebuffer updates from the loader/UART path
//  Video has strict priority. Read data goes straight from the controller to the
//  line cache; only address, command and write data pass through this block.
// PARAMETERS
//  ADDR_W      16   framebuffer address width
//  DATA_W      8    host write data width
//  TIMEOUT     255  max cycles in a WAIT state before abort (8-bit counter)
// PORTS
//  sys_clk         in   1       system clock; single clock domain
//  rst             in   1       synchronous, active-high reset
//  vblank          in   1       vertical blanking flag from sync generator
//  vid_addr        in   ADDR_W  video fetch address
//  vid_readstrobe  in   1       video fetch request; level held >=1 cycle, rising edge counts
//  vid_ready       out  1       1 = no video op pending or in flight
//  host_addr       in   ADDR_W  host write address
//  host_data       in   DATA_W  host write data
//  host_wrstrobe   in   1       host write request; rising edge counts
//  host_ready      out  1       1 = host slot free, may strobe
//  mem_addrin      out  ADDR_W  controller address
//  mem_datain      out  DATA_W  controller write data
//  mem_writeen     out  1       1 = command is a write, 0 = read
//  mem_readstrobe  out  1       one-cycle command strobe (read or write)
//  mem_ready       in   1       controller idle; drops cycle after strobe, rises on done
//  arb_err         out  1       one-cycle pulse on timeout abort
// BEHAVIOUR
//  - Reset: state IDLE; vid_ready=1, host_ready=1, mem_readstrobe=0, mem_writeen=0,
//    mem_addrin=0, mem_datain=0, arb_err=0; pending flags and timeout cleared.
//    Reset mid-operation abandons the op; nothing is replayed.
//  - Request capture: rising edges of vid_readstrobe/host_wrstrobe (registered
//    previous value) set vid_pend/host_pend and latch addr/data on the same edge.
//    vid_ready/host_ready drop the cycle after the edge, stay 0 until op done.
//    Edge while already pending: ignored (protocol violation, no side effect).
//  - States: IDLE, VID_ISSUE, VID_WAIT, HOST_ISSUE, HOST_WAIT.
//    IDLE: if mem_ready & vid_pend -> VID_ISSUE; elif mem_ready & host_pend
//      & host_ok -> HOST_ISSUE; else stay. Video wins simultaneous pendings.
//    *_ISSUE: mem_readstrobe=1 for exactly this cycle, mem_writeen=0 (VID) or 1
//      (HOST), mem_addrin/mem_datain driven from latches -> *_WAIT.
//    *_WAIT: ignore mem_ready on first WAIT cycle; then mem_ready=1 -> clear
//      pend, raise matching *_ready next cycle, -> IDLE.
//    Host op in flight when video edge arrives: host finishes; video issues on
//      the IDLE cycle right after (worst-case video latency = one host op + 2).
//  - Timeout: counter cleared on entry to WAIT; reaching TIMEOUT -> arb_err pulse,
//    clear that requester's pend, raise its ready, -> IDLE.
//  - mem_addrin/mem_datain/mem_writeen hold last value outside ISSUE.
// CONFIGURATION
//  FB_HOST_VBLANK_ONLY_EN defined: host_ok = vblank; host writes only issue
//    during vertical blank (tear-free); host_pend held across active video.
//  Undefined: host_ok = 1; host issues whenever video is idle.
// STRUCTURE
//  fb_arb_pkg: state encodings (3-bit localparams), TIMEOUT default, owner codes.
//  Sub-module: strobe_rise (1-bit registered rising-edge detector), instanced x2.
// TESTING
//  1 vid_readstrobe high 4 cycles, addr 0x0120 -> exactly one mem_readstrobe,
//    mem_writeen=0, mem_addrin=0x0120; vid_ready=0 until mem_ready returns.
//  2 host edge addr 0x1234 data 0xA5 -> one strobe, mem_writeen=1, data 0xA5,
//    host_ready back to 1 one cycle after mem_ready rises.
//  3 video and host edges same cycle -> video strobe first, host strobe after
//    video completes; no overlapping strobes.
//  4 host in WAIT, video edge arrives -> video strobe on 2nd cycle after host done.
//  5 hold mem_ready=0 after strobe -> arb_err pulse at cycle 255 of WAIT, ready=1.
//  6 FB_HOST_VBLANK_ONLY_EN, vblank=0, host edge -> no strobe; vblank rises ->
//    strobe within 2 cycles. Also rst mid-WAIT -> all outputs at reset values.

Source files
------------

// File: rtl/fb_mem_arbiter_pkg.sv
// ---------------------------------------------------------------------------
// fb_arb_pkg
//   Shared definitions for the framebuffer memory arbiter:
//   - default widths and timeout for fb_mem_arbiter
//   - 3-bit state encodings and the state enum built on them
//   - owner codes identifying which requester a state serves
//   - owner_of(): maps an arbiter state to its owner code
// ---------------------------------------------------------------------------
package fb_arb_pkg;

  localparam int ADDR_W_DEF  = 16;
  localparam int DATA_W_DEF  = 8;
  localparam int TIMEOUT_DEF = 255;
  localparam int TMR_W       = 8;

  localparam logic [2:0] ST_IDLE       = 3'd0;
  localparam logic [2:0] ST_VID_ISSUE  = 3'd1;
  localparam logic [2:0] ST_VID_WAIT   = 3'd2;
  localparam logic [2:0] ST_HOST_ISSUE = 3'd3;
  localparam logic [2:0] ST_HOST_WAIT  = 3'd4;

  typedef enum logic [2:0] {
    IDLE       = ST_IDLE,
    VID_ISSUE  = ST_VID_ISSUE,
    VID_WAIT   = ST_VID_WAIT,
    HOST_ISSUE = ST_HOST_ISSUE,
    HOST_WAIT  = ST_HOST_WAIT
  } arb_state_e;

  localparam logic [1:0] OWN_NONE = 2'd0;
  localparam logic [1:0] OWN_VID  = 2'd1;
  localparam logic [1:0] OWN_HOST = 2'd2;

  function automatic logic [1:0] owner_of(input arb_state_e st);
    logic [1:0] own;
    own = OWN_NONE;
    case (st)
      VID_ISSUE, VID_WAIT:   own = OWN_VID;
      HOST_ISSUE, HOST_WAIT: own = OWN_HOST;
      default:               own = OWN_NONE;
    endcase
    return own;
  endfunction

endpackage

// File: rtl/fb_mem_arbiter_strobe_rise.sv
// ---------------------------------------------------------------------------
// strobe_rise
//   1-bit rising-edge detector. The previous strobe level is registered;
//   rise is high combinationally while strobe=1 and the registered level is 0,
//   so the consumer acts on it at the same clock edge that updates prev.
// Ports
//   clk     in   system clock
//   rst     in   synchronous active-high reset (prev cleared)
//   strobe  in   level request input
//   rise    out  1 in the first cycle strobe is seen high
// ---------------------------------------------------------------------------
module strobe_rise (
  input  logic clk,
  input  logic rst,
  input  logic strobe,
  output logic rise
);

  logic prev;

  always_ff @(posedge clk) begin
    if (rst) begin
      prev <= 1'b0;
    end else begin
      prev <= strobe;
    end
  end

  assign rise = strobe & ~prev;

endmodule

// File: rtl/fb_mem_arbiter.sv
// ---------------------------------------------------------------------------
// fb_mem_arbiter
//   Shares the framebuffer memory controller command port between the video
//   row fetch (read) and the host byte writer (write). Video has strict
//   priority; a host op already in flight is allowed to finish. Read data does
//   not pass through here, only address, command and write data.
//
// Parameters
//   ADDR_W   framebuffer address width
//   DATA_W   host write data width
//   TIMEOUT  cycles allowed in a WAIT state before the op is abandoned
//
// Ports
//   sys_clk         in   system clock
//   rst             in   synchronous active-high reset
//   vblank          in   vertical blanking flag
//   vid_addr        in   video fetch address (latched on strobe rise)
//   vid_readstrobe  in   video fetch request, rising edge counts
//   vid_ready       out  1 = no video op pending or in flight
//   host_addr       in   host write address (latched on strobe rise)
//   host_data       in   host write data (latched on strobe rise)
//   host_wrstrobe   in   host write request, rising edge counts
//   host_ready      out  1 = host slot free
//   mem_addrin      out  controller address (holds outside ISSUE)
//   mem_datain      out  controller write data (holds outside ISSUE)
//   mem_writeen     out  1 = write command, 0 = read (holds outside ISSUE)
//   mem_readstrobe  out  one-cycle command strobe
//   mem_ready       in   controller idle
//   arb_err         out  one-cycle pulse when a WAIT times out
//
// Build option
//   FB_HOST_VBLANK_ONLY_EN  when defined, host writes only issue while vblank=1;
//                           otherwise host writes issue whenever video is idle.
//
// States
//   state      | meaning
//   IDLE       | no command outstanding; pick video first, then host
//   VID_ISSUE  | video read strobe on the controller port this cycle
//   VID_WAIT   | video read in flight, waiting for mem_ready or timeout
//   HOST_ISSUE | host write strobe on the controller port this cycle
//   HOST_WAIT  | host write in flight, waiting for mem_ready or timeout
// ---------------------------------------------------------------------------
module fb_mem_arbiter
  import fb_arb_pkg::*;
#(
  parameter int ADDR_W  = ADDR_W_DEF,
  parameter int DATA_W  = DATA_W_DEF,
  parameter int TIMEOUT = TIMEOUT_DEF
) (
  input  logic              sys_clk,
  input  logic              rst,
  input  logic              vblank,
  input  logic [ADDR_W-1:0] vid_addr,
  input  logic              vid_readstrobe,
  output logic              vid_ready,
  input  logic [ADDR_W-1:0] host_addr,
  input  logic [DATA_W-1:0] host_data,
  input  logic              host_wrstrobe,
  output logic              host_ready,
  output logic [ADDR_W-1:0] mem_addrin,
  output logic [DATA_W-1:0] mem_datain,
  output logic              mem_writeen,
  output logic              mem_readstrobe,
  input  logic              mem_ready,
  output logic              arb_err
);

  localparam logic [TMR_W-1:0] TMR_LAST = TMR_W'(TIMEOUT - 1);

  arb_state_e        state;
  logic              vid_pend;
  logic              host_pend;
  logic [ADDR_W-1:0] vid_addr_q;
  logic [ADDR_W-1:0] host_addr_q;
  logic [DATA_W-1:0] host_data_q;
  logic [TMR_W-1:0]  tmr;

  logic              vid_rise;
  logic              host_rise;
  logic              host_ok;
  logic [1:0]        cur_owner;
  logic              wait_done;
  logic              wait_tout;

  strobe_rise u_vid_rise (
    .clk    (sys_clk),
    .rst    (rst),
    .strobe (vid_readstrobe),
    .rise   (vid_rise)
  );

  strobe_rise u_host_rise (
    .clk    (sys_clk),
    .rst    (rst),
    .strobe (host_wrstrobe),
    .rise   (host_rise)
  );

`ifdef FB_HOST_VBLANK_ONLY_EN
  // Tear-free updates: host writes wait for vertical blank, pend is held.
  assign host_ok = vblank;
`else
  logic unused_vblank;
  assign unused_vblank = vblank;
  assign host_ok       = 1'b1;
`endif

  assign cur_owner = owner_of(state);

  // tmr is 0 only on the first WAIT cycle, where mem_ready may still reflect
  // the controller state from before it accepted the strobe.
  assign wait_done = (tmr != '0) && mem_ready;
  assign wait_tout = !wait_done && (tmr == TMR_LAST);

  always_ff @(posedge sys_clk) begin
    if (rst) begin
      state          <= IDLE;
      vid_pend       <= 1'b0;
      host_pend      <= 1'b0;
      vid_addr_q     <= '0;
      host_addr_q    <= '0;
      host_data_q    <= '0;
      tmr            <= '0;
      vid_ready      <= 1'b1;
      host_ready     <= 1'b1;
      mem_addrin     <= '0;
      mem_datain     <= '0;
      mem_writeen    <= 1'b0;
      mem_readstrobe <= 1'b0;
      arb_err        <= 1'b0;
    end else begin
      mem_readstrobe <= 1'b0;
      arb_err        <= 1'b0;

      // A new edge while the requester is still pending is a protocol
      // violation and is dropped without touching the latched request.
      if (vid_rise && !vid_pend) begin
        vid_pend   <= 1'b1;
        vid_addr_q <= vid_addr;
        vid_ready  <= 1'b0;
      end
      if (host_rise && !host_pend) begin
        host_pend   <= 1'b1;
        host_addr_q <= host_addr;
        host_data_q <= host_data;
        host_ready  <= 1'b0;
      end

      unique case (state)
        IDLE: begin
          if (mem_ready && vid_pend) begin
            state          <= VID_ISSUE;
            mem_readstrobe <= 1'b1;
            mem_writeen    <= 1'b0;
            mem_addrin     <= vid_addr_q;
          end else if (mem_ready && host_pend && host_ok) begin
            state          <= HOST_ISSUE;
            mem_readstrobe <= 1'b1;
            mem_writeen    <= 1'b1;
            mem_addrin     <= host_addr_q;
            mem_datain     <= host_data_q;
          end
        end

        VID_ISSUE: begin
          state <= VID_WAIT;
          tmr   <= '0;
        end

        HOST_ISSUE: begin
          state <= HOST_WAIT;
          tmr   <= '0;
        end

        VID_WAIT, HOST_WAIT: begin
          if (wait_done || wait_tout) begin
            state   <= IDLE;
            arb_err <= wait_tout;
            if (cur_owner == OWN_VID) begin
              vid_pend  <= 1'b0;
              vid_ready <= 1'b1;
            end else begin
              host_pend  <= 1'b0;
              host_ready <= 1'b1;
            end
          end else begin
            tmr <= tmr + 1'b1;
          end
        end

        default: state <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_fb_mem_arbiter.sv
module tb_fb_mem_arbiter;

  logic        sys_clk = 1'b0;
  logic        rst = 1'b1;
  logic        vblank = 1'b0;
  logic [15:0] vid_addr = '0;
  logic        vid_readstrobe = 1'b0;
  logic        vid_ready;
  logic [15:0] host_addr = '0;
  logic [7:0]  host_data = '0;
  logic        host_wrstrobe = 1'b0;
  logic        host_ready;
  logic [15:0] mem_addrin;
  logic [7:0]  mem_datain;
  logic        mem_writeen;
  logic        mem_readstrobe;
  logic        mem_ready = 1'b1;
  logic        arb_err;

  typedef struct packed {
    logic        we;
    logic [15:0] addr;
    logic [7:0]  data;
  } cmd_t;

  cmd_t exp_q[$];
  int   n_cmp = 0;
  int   n_bad = 0;
  int   cyc = 0;
  int   strobe_cnt = 0;
  int   last_strobe_cyc = -1;
  int   mr_rise_cyc = -1;

  // controller model knobs
  int   ctl_lat = 3;
  bit   ctl_hang = 1'b0;

  fb_mem_arbiter dut (
    .sys_clk        (sys_clk),
    .rst            (rst),
    .vblank         (vblank),
    .vid_addr       (vid_addr),
    .vid_readstrobe (vid_readstrobe),
    .vid_ready      (vid_ready),
    .host_addr      (host_addr),
    .host_data      (host_data),
    .host_wrstrobe  (host_wrstrobe),
    .host_ready     (host_ready),
    .mem_addrin     (mem_addrin),
    .mem_datain     (mem_datain),
    .mem_writeen    (mem_writeen),
    .mem_readstrobe (mem_readstrobe),
    .mem_ready      (mem_ready),
    .arb_err        (arb_err)
  );

  always #5 sys_clk = ~sys_clk;

  always @(posedge sys_clk) cyc <= cyc + 1;

  // Controller: mem_ready drops the cycle after a strobe, rises ctl_lat cycles later.
  initial begin
    int  busy;
    bit  saw;
    busy = 0;
    saw  = 1'b0;
    forever begin
      @(posedge sys_clk);
      #1;
      if (rst) begin
        saw       = 1'b0;
        busy      = 0;
        mem_ready = 1'b1;
      end else if (saw) begin
        saw       = 1'b0;
        mem_ready = 1'b0;
        busy      = ctl_lat;
      end else if (busy > 0) begin
        busy--;
        if (busy == 0 && !ctl_hang) mem_ready = 1'b1;
      end
      if (!rst && mem_readstrobe) saw = 1'b1;
    end
  end

  // Scoreboard monitor on the falling edge.
  initial begin
    logic mr_prev;
    cmd_t e;
    mr_prev = 1'b1;
    forever begin
      @(negedge sys_clk);
      if (!rst) begin
        if (mem_ready && !mr_prev) mr_rise_cyc = cyc;
        if (mem_readstrobe) begin
          strobe_cnt++;
          last_strobe_cyc = cyc;
          n_cmp++;
          if (!mem_ready) begin
            n_bad++;
            $display("FAIL overlap: strobe at cycle %0d with mem_ready=%b, required mem_ready=1", cyc, mem_ready);
          end
          n_cmp++;
          if (exp_q.size() == 0) begin
            n_bad++;
            $display("FAIL unexpected_strobe: got we=%b addr=%h data=%h, required no strobe", mem_writeen, mem_addrin, mem_datain);
          end else begin
            e = exp_q.pop_front();
            if (mem_writeen !== e.we || mem_addrin !== e.addr || (e.we && mem_datain !== e.data)) begin
              n_bad++;
              $display("FAIL cmd: got we=%b addr=%h data=%h, required we=%b addr=%h data=%h",
                       mem_writeen, mem_addrin, mem_datain, e.we, e.addr, e.data);
            end
          end
        end
      end
      mr_prev = mem_ready;
    end
  end

  initial begin
    #500000;
    $display("FAIL watchdog: simulation did not finish, required completion");
    $fatal(1, "watchdog");
  end

  task automatic tick(input int n);
    repeat (n) @(negedge sys_clk);
  endtask

  task automatic wait_idle(input string name, input int budget);
    int n;
    n = 0;
    while (!(vid_ready && host_ready && mem_ready && exp_q.size() == 0) && n < budget) begin
      tick(1);
      n++;
    end
    n_cmp++;
    if (!(vid_ready && host_ready && mem_ready && exp_q.size() == 0)) begin
      n_bad++;
      $display("FAIL %s_idle: not idle after %0d cycles (queue %0d), required idle", name, budget, exp_q.size());
    end
  endtask

  task automatic check_reset_outputs(input string name);
    n_cmp++;
    if (vid_ready !== 1'b1 || host_ready !== 1'b1 || mem_readstrobe !== 1'b0 || mem_writeen !== 1'b0 ||
        mem_addrin !== 16'h0000 || mem_datain !== 8'h00 || arb_err !== 1'b0) begin
      n_bad++;
      $display("FAIL %s: got vr=%b hr=%b stb=%b we=%b a=%h d=%h err=%b, required 1 1 0 0 0000 00 0",
               name, vid_ready, host_ready, mem_readstrobe, mem_writeen, mem_addrin, mem_datain, arb_err);
    end
  endtask

  task automatic test_reset;
    rst = 1'b1;
    tick(3);
    check_reset_outputs("reset");
    rst = 1'b0;
    tick(2);
    check_reset_outputs("post_reset");
  endtask

  task automatic test_video_read;
    int c0, s0, rc, n;
    ctl_lat = 3;
    s0 = strobe_cnt;
    c0 = cyc;
    vid_addr = 16'h0120;
    vid_readstrobe = 1'b1;
    exp_q.push_back(cmd_t'{we: 1'b0, addr: 16'h0120, data: 8'h00});
    tick(1);
    n_cmp++;
    if (vid_ready !== 1'b0) begin
      n_bad++;
      $display("FAIL vid_ready_drop: got %b, required 0", vid_ready);
    end
    tick(3);
    vid_readstrobe = 1'b0;
    n_cmp++;
    if (vid_ready !== 1'b0) begin
      n_bad++;
      $display("FAIL vid_ready_busy: got %b, required 0", vid_ready);
    end
    n = 0;
    while (!vid_ready && n < 40) begin tick(1); n++; end
    rc = cyc;
    n_cmp++;
    if (!vid_ready) begin
      n_bad++;
      $display("FAIL vid_done_timeout: vid_ready=%b after 40 cycles, required 1", vid_ready);
    end
    n_cmp++;
    if (strobe_cnt - s0 != 1) begin
      n_bad++;
      $display("FAIL vid_strobe_count: got %0d, required 1", strobe_cnt - s0);
    end
    n_cmp++;
    if (last_strobe_cyc != c0 + 2) begin
      n_bad++;
      $display("FAIL vid_latency: strobe at cycle %0d, required %0d", last_strobe_cyc, c0 + 2);
    end
    n_cmp++;
    if (rc != mr_rise_cyc + 1) begin
      n_bad++;
      $display("FAIL vid_ready_return: at cycle %0d, required %0d", rc, mr_rise_cyc + 1);
    end
    wait_idle("video", 20);
  endtask

  task automatic test_host_write;
    int s0, rc, n;
    ctl_lat = 3;
    s0 = strobe_cnt;
    host_addr = 16'h1234;
    host_data = 8'hA5;
    host_wrstrobe = 1'b1;
    exp_q.push_back(cmd_t'{we: 1'b1, addr: 16'h1234, data: 8'hA5});
    tick(2);
    host_wrstrobe = 1'b0;
    host_data = 8'h00;
    n = 0;
    while (!host_ready && n < 40) begin tick(1); n++; end
    rc = cyc;
    n_cmp++;
    if (rc != mr_rise_cyc + 1 || !host_ready) begin
      n_bad++;
      $display("FAIL host_ready_return: at cycle %0d (ready=%b), required %0d", rc, host_ready, mr_rise_cyc + 1);
    end
    n_cmp++;
    if (strobe_cnt - s0 != 1) begin
      n_bad++;
      $display("FAIL host_strobe_count: got %0d, required 1", strobe_cnt - s0);
    end
    tick(3);
    n_cmp++;
    if (mem_datain !== 8'hA5 || mem_writeen !== 1'b1) begin
      n_bad++;
      $display("FAIL host_hold: got we=%b data=%h, required 1 a5", mem_writeen, mem_datain);
    end
  endtask

  task automatic test_simultaneous;
    int s0;
    ctl_lat = 4;
    s0 = strobe_cnt;
    vid_addr = 16'h4400;
    host_addr = 16'h0055;
    host_data = 8'h3E;
    vid_readstrobe = 1'b1;
    host_wrstrobe = 1'b1;
    exp_q.push_back(cmd_t'{we: 1'b0, addr: 16'h4400, data: 8'h00});
    exp_q.push_back(cmd_t'{we: 1'b1, addr: 16'h0055, data: 8'h3E});
    tick(1);
    vid_readstrobe = 1'b0;
    host_wrstrobe = 1'b0;
    wait_idle("simultaneous", 60);
    n_cmp++;
    if (strobe_cnt - s0 != 2) begin
      n_bad++;
      $display("FAIL simul_strobe_count: got %0d, required 2", strobe_cnt - s0);
    end
  endtask

  task automatic test_host_then_video;
    int hrise, rc, n;
    ctl_lat = 6;
    host_addr = 16'h2000;
    host_data = 8'h5A;
    host_wrstrobe = 1'b1;
    exp_q.push_back(cmd_t'{we: 1'b1, addr: 16'h2000, data: 8'h5A});
    tick(1);
    host_wrstrobe = 1'b0;
    tick(3);
    vid_addr = 16'h0F80;
    vid_readstrobe = 1'b1;
    exp_q.push_back(cmd_t'{we: 1'b0, addr: 16'h0F80, data: 8'h00});
    tick(1);
    vid_readstrobe = 1'b0;
    n = 0;
    while (!host_ready && n < 40) begin tick(1); n++; end
    rc = cyc;
    hrise = mr_rise_cyc;
    n_cmp++;
    if (!host_ready || rc != hrise + 1) begin
      n_bad++;
      $display("FAIL preempt_host_done: ready=%b at cycle %0d, required 1 at %0d", host_ready, rc, hrise + 1);
    end
    wait_idle("preempt", 40);
    n_cmp++;
    if (last_strobe_cyc != hrise + 2) begin
      n_bad++;
      $display("FAIL preempt_vid_latency: strobe at cycle %0d, required %0d", last_strobe_cyc, hrise + 2);
    end
  endtask

  task automatic test_timeout;
    int s0, s, ecyc, n;
    ctl_lat = 3;
    ctl_hang = 1'b1;
    s0 = strobe_cnt;
    host_addr = 16'h0BAD;
    host_data = 8'h3C;
    host_wrstrobe = 1'b1;
    exp_q.push_back(cmd_t'{we: 1'b1, addr: 16'h0BAD, data: 8'h3C});
    tick(1);
    host_wrstrobe = 1'b0;
    n = 0;
    while (strobe_cnt == s0 && n < 10) begin tick(1); n++; end
    s = last_strobe_cyc;
    n = 0;
    while (!arb_err && n < 300) begin tick(1); n++; end
    ecyc = cyc;
    n_cmp++;
    if (!arb_err || ecyc != s + 256) begin
      n_bad++;
      $display("FAIL timeout_err: arb_err=%b at cycle %0d, required 1 at %0d", arb_err, ecyc, s + 256);
    end
    n_cmp++;
    if (host_ready !== 1'b1) begin
      n_bad++;
      $display("FAIL timeout_ready: got %b, required 1", host_ready);
    end
    tick(1);
    n_cmp++;
    if (arb_err !== 1'b0) begin
      n_bad++;
      $display("FAIL timeout_pulse_width: got %b, required 0", arb_err);
    end
    ctl_hang = 1'b0;
    mem_ready = 1'b1;
    wait_idle("timeout", 10);
  endtask

  task automatic test_reset_mid_wait;
    int s0, n;
    ctl_hang = 1'b1;
    s0 = strobe_cnt;
    vid_addr = 16'h0777;
    vid_readstrobe = 1'b1;
    exp_q.push_back(cmd_t'{we: 1'b0, addr: 16'h0777, data: 8'h00});
    tick(1);
    vid_readstrobe = 1'b0;
    n = 0;
    while (strobe_cnt == s0 && n < 10) begin tick(1); n++; end
    tick(3);
    rst = 1'b1;
    tick(1);
    check_reset_outputs("reset_mid_wait");
    ctl_hang = 1'b0;
    rst = 1'b0;
    tick(10);
    n_cmp++;
    if (strobe_cnt - s0 != 1) begin
      n_bad++;
      $display("FAIL no_replay: got %0d strobes, required 1", strobe_cnt - s0);
    end
    wait_idle("after_reset", 10);
  endtask

  task automatic test_host_gate;
    int s0;
    ctl_lat = 3;
    s0 = strobe_cnt;
    vblank = 1'b0;
    host_addr = 16'h7001;
    host_data = 8'hC3;
    host_wrstrobe = 1'b1;
    exp_q.push_back(cmd_t'{we: 1'b1, addr: 16'h7001, data: 8'hC3});
    tick(1);
    host_wrstrobe = 1'b0;
`ifdef FB_HOST_VBLANK_ONLY_EN
    tick(10);
    n_cmp++;
    if (strobe_cnt != s0 || host_ready !== 1'b0) begin
      n_bad++;
      $display("FAIL vblank_hold: got %0d strobes ready=%b, required 0 strobes ready=0", strobe_cnt - s0, host_ready);
    end
    vblank = 1'b1;
    tick(2);
    n_cmp++;
    if (strobe_cnt - s0 != 1) begin
      n_bad++;
      $display("FAIL vblank_release: got %0d strobes, required 1", strobe_cnt - s0);
    end
`else
    tick(2);
    n_cmp++;
    if (strobe_cnt - s0 != 1) begin
      n_bad++;
      $display("FAIL host_no_vblank: got %0d strobes, required 1", strobe_cnt - s0);
    end
`endif
    wait_idle("host_gate", 30);
    vblank = 1'b0;
  endtask

  task automatic test_ignore_repeat;
    int s0;
    ctl_lat = 4;
    s0 = strobe_cnt;
    host_addr = 16'h0100;
    host_data = 8'h11;
    host_wrstrobe = 1'b1;
    exp_q.push_back(cmd_t'{we: 1'b1, addr: 16'h0100, data: 8'h11});
    tick(1);
    host_wrstrobe = 1'b0;
    tick(1);
    host_addr = 16'h0200;
    host_data = 8'h22;
    host_wrstrobe = 1'b1;
    tick(1);
    host_wrstrobe = 1'b0;
    wait_idle("ignore", 40);
    n_cmp++;
    if (strobe_cnt - s0 != 1 || mem_addrin !== 16'h0100) begin
      n_bad++;
      $display("FAIL ignore_repeat: got %0d strobes addr=%h, required 1 strobe addr=0100", strobe_cnt - s0, mem_addrin);
    end
  endtask

  task automatic test_back_to_back;
    int s0;
    logic [15:0] a;
    logic [7:0]  d;
    s0 = strobe_cnt;
    for (int i = 0; i < 6; i++) begin
      ctl_lat = 1 + (i % 3);
      a = 16'($urandom);
      d = 8'($urandom);
      if (i % 2 == 0) begin
        vid_addr = a;
        vid_readstrobe = 1'b1;
        exp_q.push_back(cmd_t'{we: 1'b0, addr: a, data: 8'h00});
      end else begin
        host_addr = a;
        host_data = d;
        host_wrstrobe = 1'b1;
        exp_q.push_back(cmd_t'{we: 1'b1, addr: a, data: d});
      end
      tick(1);
      vid_readstrobe = 1'b0;
      host_wrstrobe = 1'b0;
      wait_idle("b2b", 30);
    end
    n_cmp++;
    if (strobe_cnt - s0 != 6) begin
      n_bad++;
      $display("FAIL b2b_count: got %0d strobes, required 6", strobe_cnt - s0);
    end
  endtask

  initial begin
    test_reset();
    test_video_read();
    test_host_write();
    test_simultaneous();
    test_host_then_video();
    test_timeout();
    test_reset_mid_wait();
    test_host_gate();
    test_ignore_repeat();
    test_back_to_back();
    tick(2);
    n_cmp++;
    if (exp_q.size() != 0) begin
      n_bad++;
      $display("FAIL scoreboard_drain: %0d commands outstanding, required 0", exp_q.size());
    end
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
